// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Bundles every load_store_unit signal except clock and reset.
//                This covers the upstream op, the data-memory port, the
//                register write-back and the error pulses.
//                The slave modport is the LSU's view of the bundle.
//                The master modport is the environment's view: the ALU,
//                the memory and the register file.
//  Ports       : iRead/iWrite/iAddr/iData/iOpType/iRdAddr  upstream op
//                oBusy                                     upstream stall
//                oMemReq/oMemWe/oMemAddr/oMemWData/oMemBe  memory request
//                iMemGnt/iMemRValid/iMemRData              memory response
//                oRegDv/oRegAddr/oRegData                  write-back
//                oErr                                      illegal funct3
//                oMisalign/oBadAddr  (LSU_MISALIGN_TRAP_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int XLEN      = 32,
  parameter int REG_SEL_W = 5
);
  logic                 iRead;
  logic                 iWrite;
  logic [XLEN-1:0]      iAddr;
  logic [XLEN-1:0]      iData;
  logic [2:0]           iOpType;
  logic [REG_SEL_W-1:0] iRdAddr;
  logic                 oBusy;
  logic                 oMemReq;
  logic                 oMemWe;
  logic [XLEN-1:0]      oMemAddr;
  logic [XLEN-1:0]      oMemWData;
  logic [3:0]           oMemBe;
  logic                 iMemGnt;
  logic                 iMemRValid;
  logic [XLEN-1:0]      iMemRData;
  logic                 oRegDv;
  logic [REG_SEL_W-1:0] oRegAddr;
  logic [XLEN-1:0]      oRegData;
  logic                 oErr;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                 oMisalign;
  logic [XLEN-1:0]      oBadAddr;
`endif

  modport slave (
`ifdef LSU_MISALIGN_TRAP_EN
    output oMisalign, oBadAddr,
`endif
    input  iRead, iWrite, iAddr, iData, iOpType, iRdAddr,
    input  iMemGnt, iMemRValid, iMemRData,
    output oBusy, oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe,
    output oRegDv, oRegAddr, oRegData, oErr
  );

  modport master (
`ifdef LSU_MISALIGN_TRAP_EN
    input  oMisalign, oBadAddr,
`endif
    output iRead, iWrite, iAddr, iData, iOpType, iRdAddr,
    output iMemGnt, iMemRValid, iMemRData,
    input  oBusy, oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe,
    input  oRegDv, oRegAddr, oRegData, oErr
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory stage.
//                Accepts one decoded load/store op and runs it against the
//                data-memory port using a request/grant handshake.
//                Returns load results as a register write-back.
//                Performs byte-lane steering, byte-enable generation and
//                sign/zero extension of load data.
//                oBusy is high while an access is in flight.
//  Ports       : iClk       clock
//                iRst       synchronous active-high reset
//                bus        load_store_unit_if.slave (op, memory, write-back)
//  Option      : LSU_MISALIGN_TRAP_EN
//                Misaligned half/word ops are rejected with a oMisalign
//                pulse and the offending address on oBadAddr.
//                Without this option, the low address bits of such ops are
//                truncated to natural alignment and the op proceeds.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int XLEN      = 32,
  parameter int REG_SEL_W = 5
) (
  input  logic              iClk,
  input  logic              iRst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  state_t state, next_state;

  // Op latched at accept time
  logic                 op_load;
  logic                 op_unsigned;
  logic [1:0]           op_size;
  logic [1:0]           op_lane;
  logic [REG_SEL_W-1:0] op_rd;

  // Registered outputs
  logic                 mem_req;
  logic                 mem_we;
  logic [XLEN-1:0]      mem_addr;
  logic [XLEN-1:0]      mem_wdata;
  logic [3:0]           mem_be;
  logic                 reg_dv;
  logic [REG_SEL_W-1:0] reg_addr;
  logic [XLEN-1:0]      reg_data;
  logic                 err;

  // Decode of the incoming op
  logic            req_in;
  logic            legal;
  logic [1:0]      size_in;
  logic [XLEN-1:0] addr_al;
  logic [3:0]      be_in;
  logic [XLEN-1:0] wdata_in;

  // FSM strobes
  logic accept;
  logic flag_err;
  logic flag_mis;
  logic rd_done;

  // Load data path
  logic [XLEN-1:0] rdata_sh;
  logic [XLEN-1:0] load_val;

  always_comb begin
    req_in  = bus.iRead | bus.iWrite;
    size_in = bus.iOpType[1:0];

    // A load has priority when both flags are set.
    // Legal loads are LB/LH/LW/LBU/LHU. Legal stores are SB/SH/SW.
    if (bus.iRead) begin
      legal = (bus.iOpType != 3'b011) && (bus.iOpType[2:1] != 2'b11);
    end else begin
      legal = !bus.iOpType[2] && (bus.iOpType[1:0] != 2'b11);
    end

    // Force natural alignment. With the trap enabled, misaligned ops never
    // reach this path, so the truncation is harmless there.
    case (size_in)
      SZ_BYTE: addr_al = bus.iAddr;
      SZ_HALF: addr_al = {bus.iAddr[XLEN-1:1], 1'b0};
      default: addr_al = {bus.iAddr[XLEN-1:2], 2'b00};
    endcase

    case (size_in)
      SZ_BYTE: be_in = 4'b0001 << addr_al[1:0];
      SZ_HALF: be_in = addr_al[1] ? 4'b1100 : 4'b0011;
      default: be_in = 4'b1111;
    endcase

    // Replicating the store data across the word puts it in every lane.
    // The byte enables then select the lanes actually written.
    case (size_in)
      SZ_BYTE: wdata_in = {(XLEN/8){bus.iData[7:0]}};
      SZ_HALF: wdata_in = {(XLEN/16){bus.iData[15:0]}};
      default: wdata_in = bus.iData;
    endcase
  end

  // Half lanes are always even, so a single byte-granular shifter serves
  // byte, half and word loads.
  always_comb begin
    rdata_sh = bus.iMemRData >> {op_lane, 3'b000};
    case (op_size)
      SZ_BYTE: load_val = op_unsigned ? {{(XLEN-8){1'b0}}, rdata_sh[7:0]}
                                      : {{(XLEN-8){rdata_sh[7]}}, rdata_sh[7:0]};
      SZ_HALF: load_val = op_unsigned ? {{(XLEN-16){1'b0}}, rdata_sh[15:0]}
                                      : {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
      default: load_val = bus.iMemRData;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    flag_err   = 1'b0;
    flag_mis   = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (req_in) begin
          if (!legal) begin
            flag_err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (((size_in == SZ_HALF) && bus.iAddr[0]) ||
                       ((size_in == 2'b10) && (bus.iAddr[1:0] != 2'b00))) begin
            flag_mis = 1'b1;
`endif
          end else begin
            accept     = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (bus.iMemGnt) begin
          next_state = op_load ? WAIT_RD : IDLE;
        end
      end
      WAIT_RD: begin
        if (bus.iMemRValid) begin
          rd_done    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      op_load     <= 1'b0;
      op_unsigned <= 1'b0;
      op_size     <= 2'b00;
      op_lane     <= 2'b00;
      op_rd       <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= 4'b0000;
      reg_dv      <= 1'b0;
      reg_addr    <= '0;
      reg_data    <= '0;
      err         <= 1'b0;
    end else begin
      err    <= flag_err;
      // Loads to x0 still perform the access, but they never write back.
      reg_dv <= rd_done && (op_rd != '0);

      if (accept) begin
        op_load     <= bus.iRead;
        op_unsigned <= bus.iOpType[2];
        op_size     <= size_in;
        op_lane     <= addr_al[1:0];
        op_rd       <= bus.iRdAddr;
        mem_req     <= 1'b1;
        mem_we      <= !bus.iRead;
        mem_addr    <= {addr_al[XLEN-1:2], 2'b00};
        mem_wdata   <= wdata_in;
        mem_be      <= be_in;
      end else if ((state == REQ) && bus.iMemGnt) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      if (rd_done && (op_rd != '0)) begin
        reg_addr <= op_rd;
        reg_data <= load_val;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic            misalign;
  logic [XLEN-1:0] bad_addr;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      misalign <= 1'b0;
      bad_addr <= '0;
    end else begin
      misalign <= flag_mis;
      if (flag_mis) begin
        bad_addr <= bus.iAddr;
      end
    end
  end

  assign bus.oMisalign = misalign;
  assign bus.oBadAddr  = bad_addr;
`endif

  assign bus.oBusy     = (state != IDLE);
  assign bus.oMemReq   = mem_req;
  assign bus.oMemWe    = mem_we;
  assign bus.oMemAddr  = mem_addr;
  assign bus.oMemWData = mem_wdata;
  assign bus.oMemBe    = mem_be;
  assign bus.oRegDv    = reg_dv;
  assign bus.oRegAddr  = reg_addr;
  assign bus.oRegData  = reg_data;
  assign bus.oErr      = err;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Scoreboard bench for load_store_unit.
//                Stimulus pushes the expected memory accesses, write-backs
//                and error pulses onto queues. A negedge monitor pops and
//                compares them whenever the DUT presents the matching event.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  localparam int XLEN      = 32;
  localparam int REG_SEL_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  load_store_unit_if #(.XLEN(XLEN), .REG_SEL_W(REG_SEL_W)) bus ();

  load_store_unit #(.XLEN(XLEN), .REG_SEL_W(REG_SEL_W)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  held;
  } mem_exp_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  mem_exp_t mem_q[$];
  wb_exp_t  wb_q[$];
  int       exp_err = 0;
  int       checks  = 0;
  int       fails   = 0;
  int       req_cycles = 0;
`ifdef LSU_MISALIGN_TRAP_EN
  int          exp_mis = 0;
  logic [31:0] exp_bad = '0;
`endif

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_mem(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input int held);
    mem_exp_t e;
    e.we = we; e.be = be; e.addr = addr; e.wdata = wdata; e.held = 8'(held);
    mem_q.push_back(e);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    wb_exp_t e;
    e.rd = rd; e.data = data;
    wb_q.push_back(e);
  endtask

  // Caller is 1 time unit after a posedge, in an IDLE cycle.
  task automatic run_op(input bit rd_op, input bit wr_op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] f3, input logic [4:0] rd,
                        input int gnt_delay, input logic [31:0] rdata);
    bus.iRead = rd_op; bus.iWrite = wr_op; bus.iAddr = addr; bus.iData = data;
    bus.iOpType = f3; bus.iRdAddr = rd;
    @(posedge clk); #1;
    bus.iRead = 1'b0; bus.iWrite = 1'b0;
    for (int i = 0; i < gnt_delay; i++) begin
      @(posedge clk); #1;
    end
    bus.iMemGnt = 1'b1;
    @(posedge clk); #1;
    bus.iMemGnt = 1'b0;
    if (rd_op) begin
      bus.iMemRValid = 1'b1; bus.iMemRData = rdata;
      @(posedge clk); #1;
      bus.iMemRValid = 1'b0;
    end
  endtask

  task automatic pulse_op(input bit rd_op, input bit wr_op, input logic [31:0] addr,
                          input logic [2:0] f3);
    bus.iRead = rd_op; bus.iWrite = wr_op; bus.iAddr = addr; bus.iData = 32'h0;
    bus.iOpType = f3; bus.iRdAddr = 5'd1;
    @(posedge clk); #1;
    bus.iRead = 1'b0; bus.iWrite = 1'b0;
    check("no_req_after_reject", {bus.oMemReq, bus.oBusy}, 2'b00);
    @(posedge clk); #1;
  endtask

  function automatic logic [127:0] all_outputs();
    return {18'h0, bus.oBusy, bus.oMemReq, bus.oMemWe, bus.oMemAddr, bus.oMemWData,
            bus.oMemBe, bus.oRegDv, bus.oRegAddr, bus.oRegData, bus.oErr};
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      req_cycles = 0;
    end else begin
      if (bus.oMemReq) begin
        req_cycles++;
        check("busy_during_req", bus.oBusy, 1'b1);
        if (mem_q.size() == 0) begin
          check("unexpected_mem_req", bus.oMemReq, 1'b0);
        end else begin
          check("req_addr", bus.oMemAddr, mem_q[0].addr);
          if (bus.iMemGnt) begin
            mem_exp_t e;
            e = mem_q.pop_front();
            check("mem_we", bus.oMemWe, e.we);
            check("mem_be", bus.oMemBe, e.be);
            if (e.we) check("mem_wdata", bus.oMemWData, e.wdata);
            check("req_held_cycles", req_cycles, e.held);
            req_cycles = 0;
          end
        end
      end
      if (bus.oRegDv) begin
        if (wb_q.size() == 0) begin
          check("unexpected_regdv", bus.oRegDv, 1'b0);
        end else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          check("reg_addr", bus.oRegAddr, w.rd);
          check("reg_data", bus.oRegData, w.data);
        end
      end
      if (bus.oErr) begin
        check("err_expected", exp_err > 0, 1'b1);
        if (exp_err > 0) exp_err--;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      if (bus.oMisalign) begin
        check("misalign_expected", exp_mis > 0, 1'b1);
        check("bad_addr", bus.oBadAddr, exp_bad);
        if (exp_mis > 0) exp_mis--;
      end
`endif
    end
  end

  initial begin
    rst = 1'b1;
    bus.iRead = 1'b0; bus.iWrite = 1'b0; bus.iAddr = '0; bus.iData = '0;
    bus.iOpType = 3'b000; bus.iRdAddr = '0;
    bus.iMemGnt = 1'b0; bus.iMemRValid = 1'b0; bus.iMemRData = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SW 0x100, zero-wait: idle again at T+2
    push_mem(1'b1, 4'b1111, 32'h100, 32'hDEADBEEF, 1);
    run_op(1'b1 ^ 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 5'd9, 0, 32'h0);
    check("store_idle_T2", bus.oBusy, 1'b0);

    // SB 0x103: lane 3, data replicated
    push_mem(1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5, 1);
    run_op(1'b0, 1'b1, 32'h103, 32'h000000A5, 3'b000, 5'd0, 0, 32'h0);

    // SH 0x102: upper half
    push_mem(1'b1, 4'b1100, 32'h100, 32'h12341234, 1);
    run_op(1'b0, 1'b1, 32'h102, 32'hFFFF1234, 3'b001, 5'd0, 0, 32'h0);

    // LB 0x102 rd 7: write-back at T+3
    push_mem(1'b0, 4'b0100, 32'h100, 32'h0, 1);
    push_wb(5'd7, 32'hFFFFFFF0);
    run_op(1'b1, 1'b0, 32'h102, 32'h0, 3'b000, 5'd7, 0, 32'h12F03456);
    check("load_dv_T3", bus.oRegDv, 1'b1);

    // LBU, same op
    push_mem(1'b0, 4'b0100, 32'h100, 32'h0, 1);
    push_wb(5'd7, 32'h000000F0);
    run_op(1'b1, 1'b0, 32'h102, 32'h0, 3'b100, 5'd7, 0, 32'h12F03456);

    // LH 0x102 with grant delayed 3 cycles: request held 4 cycles
    push_mem(1'b0, 4'b1100, 32'h100, 32'h0, 4);
    push_wb(5'd12, 32'hFFFF8001);
    run_op(1'b1, 1'b0, 32'h102, 32'h0, 3'b001, 5'd12, 3, 32'h80010000);

    // LHU 0x100
    push_mem(1'b0, 4'b0011, 32'h100, 32'h0, 1);
    push_wb(5'd3, 32'h00008002);
    run_op(1'b1, 1'b0, 32'h100, 32'h0, 3'b101, 5'd3, 0, 32'h80018002);

    // LB lane 1, positive byte
    push_mem(1'b0, 4'b0010, 32'h0, 32'h0, 1);
    push_wb(5'd2, 32'h0000007F);
    run_op(1'b1, 1'b0, 32'h001, 32'h0, 3'b000, 5'd2, 0, 32'h00007F00);

    // LW 0x204 rd 31
    push_mem(1'b0, 4'b1111, 32'h204, 32'h0, 1);
    push_wb(5'd31, 32'h89ABCDEF);
    run_op(1'b1, 1'b0, 32'h204, 32'h0, 3'b010, 5'd31, 0, 32'h89ABCDEF);

    // Read and write both set: load wins
    push_mem(1'b0, 4'b1111, 32'h300, 32'h0, 1);
    push_wb(5'd4, 32'h11223344);
    run_op(1'b1, 1'b1, 32'h300, 32'h0, 3'b010, 5'd4, 0, 32'h11223344);

    // Illegal funct3: load 011, store 100
    exp_err++;
    pulse_op(1'b1, 1'b0, 32'h100, 3'b011);
    exp_err++;
    pulse_op(1'b0, 1'b1, 32'h100, 3'b100);

    // LW to x0: access happens, no write-back
    push_mem(1'b0, 4'b1111, 32'h400, 32'h0, 1);
    run_op(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 5'd0, 0, 32'hCAFEF00D);
    check("rd0_no_dv", bus.oRegDv, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    exp_mis++;
    exp_bad = 32'h101;
    pulse_op(1'b1, 1'b0, 32'h101, 3'b010);
`else
    // Misaligned word/half are truncated to natural alignment
    push_mem(1'b0, 4'b1111, 32'h100, 32'h0, 1);
    push_wb(5'd5, 32'h01020304);
    run_op(1'b1, 1'b0, 32'h101, 32'h0, 3'b010, 5'd5, 0, 32'h01020304);
    push_mem(1'b0, 4'b1100, 32'h100, 32'h0, 1);
    push_wb(5'd6, 32'hFFFFBEEF);
    run_op(1'b1, 1'b0, 32'h103, 32'h0, 3'b001, 5'd6, 0, 32'hBEEF0000);
`endif

    // Reset in WAIT_RD: late read data must not write back
    push_mem(1'b0, 4'b1111, 32'h500, 32'h0, 1);
    bus.iRead = 1'b1; bus.iAddr = 32'h500; bus.iOpType = 3'b010; bus.iRdAddr = 5'd8;
    @(posedge clk); #1;
    bus.iRead = 1'b0; bus.iMemGnt = 1'b1;
    @(posedge clk); #1;
    bus.iMemGnt = 1'b0;
    check("busy_in_wait_rd", bus.oBusy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_op_outputs", all_outputs(), 128'h0);
    rst = 1'b0;
    bus.iMemRValid = 1'b1; bus.iMemRData = 32'h55555555;
    @(posedge clk); #1;
    bus.iMemRValid = 1'b0;
    check("late_rvalid_ignored", {bus.oRegDv, bus.oBusy}, 2'b00);

    // Stray grant in IDLE
    bus.iMemGnt = 1'b1;
    @(posedge clk); #1;
    bus.iMemGnt = 1'b0;
    check("stray_gnt_ignored", {bus.oMemReq, bus.oBusy}, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    check("mem_q_drained", mem_q.size(), 0);
    check("wb_q_drained", wb_q.size(), 0);
    check("err_all_seen", exp_err, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("misalign_all_seen", exp_mis, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage of the core: the responder for the ALU's memory-op output.
- Accepts one decoded load/store op (address, store data, funct3, rd), runs it against the data-memory port with a request/grant handshake, and returns load results as a register write-back.
- Handles byte-lane steering, byte enables, and sign/zero extension; stalls upstream while a transaction is in flight.

Parameters:
- XLEN, 32, data/address width.
- REG_SEL_W, 5, register-address width.

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iRead  in  1  load request (ALU mem-op read flag)
- iWrite  in  1  store request (ALU mem-op write flag)
- iAddr  in  XLEN  effective byte address
- iData  in  XLEN  store data, right-aligned
- iOpType  in  3  funct3
- iRdAddr  in  REG_SEL_W  load destination register
- oBusy  out  1  high while state != IDLE; upstream holds op
- oMemReq  out  1  data-memory request
- oMemWe  out  1  1=write
- oMemAddr  out  XLEN  word-aligned address (low 2 bits 0)
- oMemWData  out  XLEN  lane-shifted store data
- oMemBe  out  4  byte enables
- iMemGnt  in  1  request accepted
- iMemRValid  in  1  read data valid
- iMemRData  in  XLEN  read word
- oRegDv  out  1  write-back valid pulse
- oRegAddr  out  REG_SEL_W  write-back register
- oRegData  out  XLEN  extended load data
- oErr  out  1  one-cycle pulse: illegal funct3

Behaviour:
- Reset: state IDLE; every output is 0 in the cycle after iRst is sampled high. Reset mid-transaction abandons the op; late iMemGnt/iMemRValid arrivals are ignored in IDLE.
- States: IDLE, REQ, WAIT_RD.
- IDLE:
  - If iRead|iWrite, latch all inputs and go to REQ. iRead wins if both are set.
  - Without a request, stay in IDLE.
  - Inputs are ignored outside IDLE.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code pulses oErr the next cycle, makes no memory access, and stays in IDLE.
- Byte enables (lane = addr[1:0]):
  - Byte: 4'b0001 << lane.
  - Half: 4'b0011 << (addr[1]*2).
  - Word: 4'b1111.
  - Store data is replicated or shifted into the enabled lanes.
- REQ:
  - oMemReq, oMemWe, oMemAddr, oMemWData, oMemBe are registered and held stable until iMemGnt.
  - On grant, a store returns to IDLE and a load goes to WAIT_RD.
- WAIT_RD:
  - On iMemRValid, select lane bytes, sign-extend (LB/LH) or zero-extend (LBU/LHU/LW), and register oRegData/oRegAddr with a one-cycle oRegDv. Return to IDLE the same edge.
  - iMemRValid seen during REQ is ignored; it is legal no earlier than the cycle after grant.
- rd = 0 load: the access is performed, but oRegDv is suppressed.
- Latency, zero-wait memory (gnt same cycle as req, rvalid next cycle):
  - Store: accept at T, req at T+1, IDLE at T+2.
  - Load: oRegDv at T+3.
  - Next op can be accepted at T+2 (store) or T+3 (load).
- Address arithmetic is modulo 2^XLEN. No exceptions other than those listed.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Without it: misaligned half/word ops have their low address bits truncated to natural alignment (half: addr[0] forced 0; word: addr[1:0] forced 0) and proceed normally.
- With it:
  - Adds outputs oMisalign (1) and oBadAddr (XLEN).
  - A half op with addr[0]=1, or a word op with addr[1:0]!=0, makes no memory access.
  - It pulses oMisalign for one cycle with oBadAddr = original address, then stays in IDLE.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, gnt same cycle → oMemAddr 0x100, oMemBe 4'b1111, oMemWData 0xDEADBEEF, oMemWe 1; no oRegDv; oBusy low at T+2.
- SB addr 0x103, data 0x000000A5 → oMemAddr 0x100, oMemBe 4'b1000, oMemWData[31:24] = 0xA5.
- LB addr 0x102, rd 7, rdata 0x12F03456 → oRegDv at T+3, oRegAddr 7, oRegData 0xFFFFFFF0. Same op as LBU → 0x000000F0.
- LH addr 0x102, rdata 0x80010000, gnt delayed 3 cycles → oMemReq held 4 cycles with stable address; oRegData 0xFFFF8001; oBusy high throughout.
- funct3 011 with iRead → oErr pulse, oMemReq stays 0. LW to rd 0 → access issued, oRegDv stays 0.
- iRst asserted in WAIT_RD, then iMemRValid → no oRegDv; all outputs 0. With LSU_MISALIGN_TRAP_EN, LW addr 0x101 → oMisalign pulse, oBadAddr 0x101, no oMemReq.
